// File: rtl/crossbar_reader_pkg.sv
// Shared encodings for the crossbar register bank: FSM states,
// bank size and the order-vector index helper.
package crossbar_reader_pkg;

  localparam int NREG  = 4;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Order packs {idx3,idx2,idx1,idx0}; 0..3 selects R1..R4.
  function automatic logic [1:0] sel_of(
    input logic [7:0] ord,
    input logic [1:0] idx
  );
    return ord[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/crossbar_reader_read_mux.sv
// 4:1 word selector over the snapshot registers.
module read_mux #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end

endmodule

// File: rtl/crossbar_reader.sv
// Snapshots R1..R4 and an order vector on Start, then drains the
// four words in that order over a Valid/Ready handshake.
module crossbar_reader
  import crossbar_reader_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter bit CLEAR_OUT = 1'b1
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Start,
  input  logic [7:0]   Order,
  input  logic [W-1:0] R1,
  input  logic [W-1:0] R2,
  input  logic [W-1:0] R3,
  input  logic [W-1:0] R4,
  input  logic         Ready,
  output logic [W-1:0] DataOut,
  output logic         Valid,
  output logic         Busy,
  output logic         Done
);

  state_e       state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [7:0]   order_q, order_d;
  logic [W-1:0] snap_q [NREG];
  logic [W-1:0] snap_d [NREG];
  logic [W-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] mux_y;

  // Selecting on next-state values keeps DataOut a plain flop.
  read_mux #(.W(W)) u_mux (
    .d0  (snap_d[0]),
    .d1  (snap_d[1]),
    .d2  (snap_d[2]),
    .d3  (snap_d[3]),
    .sel (sel_of(order_d, idx_d)),
    .y   (mux_y)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    order_d = order_q;
    snap_d  = snap_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          snap_d[0] = R1;
          snap_d[1] = R2;
          snap_d[2] = R3;
          snap_d[3] = R4;
          order_d   = Order;
          idx_d     = 2'd0;
          state_d   = ST_SEND;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_SEND: begin
        if (Ready) begin
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    if (valid_d)        dout_d = mux_y;
    else if (CLEAR_OUT) dout_d = '0;
    else                dout_d = dout_q;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      order_q <= 8'd0;
      for (int i = 0; i < NREG; i++) snap_q[i] <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      order_q <= order_d;
      snap_q  <= snap_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign DataOut = dout_q;
  assign Valid   = valid_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule
